mem_stage: RTL

- Fourth stage of the 5-stage in-order LoongArch pipeline, between exe_stage and wb_stage.
- Latches one instruction from EXE and issues its load/store on the SRAM-like data port.
- Waits for the response, then aligns and sign/zero-extends load data.
- Forwards the result bundle to WB, plus a forwarding/stall bus to ID.

---
 rtl/mem_stage_pkg.sv | 32 +++
 rtl/mem_load_extend.sv | 25 ++
 rtl/mem_stage.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, access-size codes, state encodings and the EXE->MEM bundle layout
// used by the MEM stage.
package mem_stage_pkg;

    localparam int EXE_TO_MEM_BUS_WIDTH = 107;
    localparam int MEM_TO_WB_BUS_WIDTH  = 70;
    localparam int MEM_TO_ID_BUS_WIDTH  = 40;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] rkd_value;
        logic        is_load;
        logic        is_store;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic        reg_we;
        logic [4:0]  reg_waddr;
    } exe_to_mem_t;

endpackage

// File: rtl/mem_load_extend.sv
// Selects the addressed byte/half out of a read word and zero- or sign-extends it.
module mem_load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            MEM_SIZE_B: result_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
            MEM_SIZE_H: result_o = {{16{~uns_i & half_sel[15]}}, half_sel};
            default:    result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, runs its load/store on the SRAM-like
// data port, and hands the result to WB plus a forwarding/stall view to ID.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            exe_to_mem_valid,
    input  logic [EXE_TO_MEM_BUS_WIDTH-1:0] exe_to_mem_bus,
    output logic                            mem_allow_in,
    output logic                            mem_to_wb_valid,
    input  logic                            wb_allow_in,
    output logic [MEM_TO_WB_BUS_WIDTH-1:0]  mem_to_wb_bus,
    output logic [MEM_TO_ID_BUS_WIDTH-1:0]  mem_to_id_bus,
    output logic                            data_sram_req,
    output logic                            data_sram_wr,
    output logic [1:0]                      data_sram_size,
    output logic [3:0]                      data_sram_wstrb,
    output logic [31:0]                     data_sram_addr,
    output logic [31:0]                     data_sram_wdata,
    input  logic                            data_sram_addr_ok,
    input  logic                            data_sram_data_ok,
    input  logic [31:0]                     data_sram_rdata
);

    // state | meaning
    // IDLE  | no memory access in flight (empty or non-memory instruction)
    // REQ   | request driven, waiting for addr_ok
    // WAIT  | request accepted, waiting for data_ok
    // DONE  | response captured in rdata_buf, waiting for WB to take it

    exe_to_mem_t in_s;
    exe_to_mem_t mem_reg_q;
    mem_state_e  state_q, state_d;
    logic        mem_valid_q;
    logic [31:0] rdata_buf_q;
    logic        in_is_mem, is_mem, ready_go, reg_we_eff, data_pending;
    logic [31:0] load_value, final_result;

    assign in_s      = exe_to_mem_bus;
    assign in_is_mem = in_s.is_load | in_s.is_store;
    assign is_mem    = mem_reg_q.is_load | mem_reg_q.is_store;

    assign ready_go        = !is_mem || (state_q == ST_DONE);
    assign mem_allow_in    = !mem_valid_q || (ready_go && wb_allow_in);
    assign mem_to_wb_valid = mem_valid_q && ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
        end else begin
            state_q <= state_d;
            if (mem_allow_in) mem_valid_q <= exe_to_mem_valid;
        end
    end

    // Instruction and read buffer carry no reset: they are qualified by mem_valid_q/state_q.
    always_ff @(posedge clk) begin
        if (mem_allow_in && exe_to_mem_valid) mem_reg_q <= in_s;
        if (state_q == ST_WAIT && data_sram_data_ok) rdata_buf_q <= data_sram_rdata;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ:  if (data_sram_addr_ok) state_d = ST_WAIT;
            ST_WAIT: if (data_sram_data_ok) state_d = ST_DONE;
            default: state_d = state_q;
        endcase
        if (mem_allow_in) state_d = (exe_to_mem_valid && in_is_mem) ? ST_REQ : ST_IDLE;
    end

    always_comb begin
        data_sram_req   = (state_q == ST_REQ);
        data_sram_wr    = mem_reg_q.is_store;
        data_sram_size  = mem_reg_q.mem_size;
        data_sram_addr  = mem_reg_q.alu_result;
        data_sram_wstrb = 4'b0000;
        data_sram_wdata = mem_reg_q.rkd_value;
        case (mem_reg_q.mem_size)
            MEM_SIZE_B: begin
                data_sram_wstrb = 4'b0001 << mem_reg_q.alu_result[1:0];
                data_sram_wdata = {4{mem_reg_q.rkd_value[7:0]}};
            end
            MEM_SIZE_H: begin
                data_sram_addr[0] = 1'b0;
                data_sram_wstrb   = mem_reg_q.alu_result[1] ? 4'b1100 : 4'b0011;
                data_sram_wdata   = {2{mem_reg_q.rkd_value[15:0]}};
            end
            default: begin
                data_sram_addr[1:0] = 2'b00;
                data_sram_wstrb     = 4'b1111;
            end
        endcase
        if (!mem_reg_q.is_store) data_sram_wstrb = 4'b0000;
    end

    mem_load_extend u_load_extend (
        .rdata_i  (rdata_buf_q),
        .addr_i   (mem_reg_q.alu_result[1:0]),
        .size_i   (mem_reg_q.mem_size),
        .uns_i    (mem_reg_q.mem_unsigned),
        .result_o (load_value)
    );

    assign final_result = mem_reg_q.is_load ? load_value : mem_reg_q.alu_result;
    assign reg_we_eff   = mem_reg_q.reg_we && !mem_reg_q.is_store;
    assign data_pending = mem_valid_q && mem_reg_q.is_load && (state_q != ST_DONE);

    assign mem_to_wb_bus = {mem_reg_q.pc, final_result, reg_we_eff, mem_reg_q.reg_waddr};
    assign mem_to_id_bus = {mem_valid_q, reg_we_eff, mem_reg_q.reg_waddr, final_result, data_pending};

endmodule
